// File: rtl/psram_pkg.sv
// Shared definitions for the SPI-mode PSRAM reader: opcodes, FSM states
// and the fixed length of the command + address header.
package psram_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_READ_ID   = 8'h9F;
    localparam logic [7:0] OP_RESET_EN  = 8'h66;
    localparam logic [7:0] OP_RESET     = 8'h99;

    // Command byte plus 24-bit address, shifted out before any data comes back
    localparam int HEADER_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_HOLD,
        ST_GAP
    } state_t;

endpackage

// File: rtl/psram_spi_shifter.sv
// SCLK generator and MOSI shifter for the PSRAM reader. While i_run is high
// it produces bit periods of 2*CLK_DIV clocks (low half, then high half),
// shifts the header out MSB first, and tells the FSM when the MISO sample
// edge and the end of each bit occur.
module psram_spi_shifter
    import psram_pkg::*;
#(
    parameter int                      CLK_DIV = 2,
    parameter logic [HEADER_BITS-1:0]  HEADER  = '0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_load,
    input  logic i_run,
    output logic o_sclk,
    output logic o_mosi,
    output logic o_sample,
    output logic o_bit_done
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]        r_div;
    logic                    r_phase;
    logic                    r_sclk;
    logic [HEADER_BITS-1:0]  r_tx;
    logic                    w_half_end;

    assign w_half_end = i_run && (r_div == DIV_LAST);
    assign o_sample   = w_half_end && !r_phase;
    assign o_bit_done = w_half_end && r_phase;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_tx[HEADER_BITS-1];

    // Divider and phase: SCLK rises at the end of each low half, falls (and
    // MOSI advances, zero-filling so READ sends 0) at the end of each high half.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            r_tx    <= '0;
        end else begin
            if (i_load) begin
                r_tx <= HEADER;
            end
            if (!i_run) begin
                r_div   <= '0;
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
            end else if (w_half_end) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                r_sclk  <= ~r_phase;
                if (r_phase) begin
                    r_tx <= {r_tx[HEADER_BITS-2:0], 1'b0};
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psram_spi_reader.sv
// SPI-mode PSRAM read master: sends a command byte and 24-bit address, then
// clocks in DATA_BYTES bytes and presents them as one word with a single-cycle
// rvalid. CE framing, busy and the returned word are all registered.
module psram_spi_reader
    import psram_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter logic [7:0]  CMD        = OP_READ_ID,
    parameter logic [23:0] ADDR       = 24'h000000,
    parameter int          DATA_BYTES = 12,
    parameter int          GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic                    busy,
    output logic [8*DATA_BYTES-1:0] rdata,
    output logic                    rvalid,
    output logic                    ram_ce_n,
    output logic                    ram_clk,
    output logic                    ram_si,
    input  logic                    ram_so
);

    localparam int RX_W       = 8 * DATA_BYTES;
    localparam int TOTAL_BITS = HEADER_BITS + RX_W;
    localparam int BIT_W      = $clog2(TOTAL_BITS);
    localparam int CNT_MAX    = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_CMD_BIT  = BIT_W'(7);
    localparam logic [BIT_W-1:0] LAST_ADDR_BIT = BIT_W'(HEADER_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] SETUP_END     = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HOLD_END      = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END       = CNT_W'(GAP_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [RX_W-1:0]   r_shift;
    logic [RX_W-1:0]   r_rdata;
    logic              r_rvalid;
    logic              r_ce_n;
    logic              r_busy;
    logic              w_load;
    logic              w_run;
    logic              w_sample;
    logic              w_bit_done;
    logic              w_sclk;
    logic              w_mosi;

    assign w_run = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_READ);

    psram_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .HEADER  ({CMD, ADDR})
    ) u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_run      (w_run),
        .o_sclk     (w_sclk),
        .o_mosi     (w_mosi),
        .o_sample   (w_sample),
        .o_bit_done (w_bit_done)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; SETUP spans the accept cycle plus CLK_DIV low cycles
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SETUP;
                    w_load       = 1'b1;
                end
            end
            ST_SETUP: if (r_cnt == SETUP_END) w_state_next = ST_CMD;
            ST_CMD:   if (w_bit_done && r_bitcnt == LAST_CMD_BIT)  w_state_next = ST_ADDR;
            ST_ADDR:  if (w_bit_done && r_bitcnt == LAST_ADDR_BIT) w_state_next = ST_READ;
            ST_READ:  if (w_bit_done && r_bitcnt == LAST_BIT)      w_state_next = ST_HOLD;
            ST_HOLD:  if (r_cnt == HOLD_END) w_state_next = ST_GAP;
            ST_GAP:   if (r_cnt == GAP_END)  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Counters, receive shift register and registered interface outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_ce_n   <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            if ((w_state_next != r_state) || !(r_state inside {ST_SETUP, ST_HOLD, ST_GAP})) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_bitcnt <= '0;
            end else if (w_bit_done && (r_bitcnt != LAST_BIT)) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            if (w_load) begin
                r_shift <= '0;
            end else if (w_sample && (r_state == ST_READ)) begin
                r_shift <= {r_shift[RX_W-2:0], ram_so};
            end

            r_ce_n   <= (w_state_next == ST_IDLE) || (w_state_next == ST_GAP);
            r_busy   <= (w_state_next != ST_IDLE);
            r_rvalid <= (r_state == ST_HOLD) && (w_state_next == ST_GAP);
            if ((r_state == ST_HOLD) && (w_state_next == ST_GAP)) begin
                r_rdata <= r_shift;
            end
        end
    end

    assign busy     = r_busy;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign ram_ce_n = r_ce_n;
    assign ram_clk  = w_sclk;
    assign ram_si   = w_mosi;

endmodule

// File: tb/tb_psram_spi_reader.sv
// Directed bench for psram_spi_reader: one instance with default parameters
// and one with CLK_DIV=1 / READ 0x123456 / 2 bytes, each attached to a small
// serial PSRAM model that answers with a fixed byte string after the header.
module tb_psram_spi_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        busy1, busy2;
    logic [95:0] rdata1;
    logic [15:0] rdata2;
    logic        rvalid1, rvalid2;
    logic        ramCeN1, ramCeN2;
    logic        ramClk1, ramClk2;
    logic        ramSi1, ramSi2;
    logic        ramSo1 = 1'b0;
    logic        ramSo2 = 1'b0;

    logic [95:0] resp1 = 96'h0D5D52A60123456789ABCDEF;
    logic [15:0] resp2 = 16'hA53C;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Model state for instance 1
    int          rises1 = 0, lastRises1 = 0, siBad1 = 0, clkIdleBad1 = 0;
    int          ceRun1 = 0, lastCeRun1 = 0, rvCount1 = 0;
    logic [31:0] mosiHdr1 = '0;
    logic        prevCe1 = 1'b1, prevSclk1 = 1'b0, prevSi1 = 1'b0;

    // Model state for instance 2
    int          rises2 = 0, lastRises2 = 0, siBad2 = 0, clkIdleBad2 = 0;
    int          rvCount2 = 0;
    logic [31:0] mosiHdr2 = '0;
    logic        prevCe2 = 1'b1, prevSclk2 = 1'b0, prevSi2 = 1'b0;

    int acceptCycle = 0;

    psram_spi_reader u_dut1 (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start1),
        .busy     (busy1),
        .rdata    (rdata1),
        .rvalid   (rvalid1),
        .ram_ce_n (ramCeN1),
        .ram_clk  (ramClk1),
        .ram_si   (ramSi1),
        .ram_so   (ramSo1)
    );

    psram_spi_reader #(
        .CLK_DIV    (1),
        .CMD        (8'h03),
        .ADDR       (24'h123456),
        .DATA_BYTES (2),
        .GAP_CYCLES (8)
    ) u_dut2 (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start2),
        .busy     (busy2),
        .rdata    (rdata2),
        .rvalid   (rvalid2),
        .ram_ce_n (ramCeN2),
        .ram_clk  (ramClk2),
        .ram_si   (ramSi2),
        .ram_so   (ramSo2)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    // Free-running cycle counter used for latency measurements
    always @(posedge clk) cyc = cyc + 1;

    // PSRAM model 1: captures MOSI on SCLK rise, shifts data out after SCLK fall,
    // and tracks SCLK/CE waveform rules, CE-high run lengths and rvalid pulses
    always @(negedge clk) begin
        if (prevCe1 && !ramCeN1) begin
            rises1   = 0;
            mosiHdr1 = '0;
            ramSo1   = 1'b0;
        end
        if (!ramCeN1 && !prevSclk1 && ramClk1) begin
            if (ramSi1 !== prevSi1) siBad1++;
            if (rises1 < 32) mosiHdr1 = {mosiHdr1[30:0], ramSi1};
            rises1++;
        end
        if (!ramCeN1 && prevSclk1 && !ramClk1 && rises1 >= 32 && rises1 < 128) begin
            ramSo1 = resp1[127 - rises1];
        end
        if (!prevCe1 && ramCeN1) lastRises1 = rises1;
        if (ramCeN1 && ramClk1) clkIdleBad1++;
        if (ramCeN1) begin
            ceRun1++;
        end else begin
            if (ceRun1 != 0) lastCeRun1 = ceRun1;
            ceRun1 = 0;
        end
        if (rvalid1) rvCount1++;
        prevCe1   = ramCeN1;
        prevSclk1 = ramClk1;
        prevSi1   = ramSi1;
    end

    // PSRAM model 2: same behaviour for the 2-byte instance
    always @(negedge clk) begin
        if (prevCe2 && !ramCeN2) begin
            rises2   = 0;
            mosiHdr2 = '0;
            ramSo2   = 1'b0;
        end
        if (!ramCeN2 && !prevSclk2 && ramClk2) begin
            if (ramSi2 !== prevSi2) siBad2++;
            if (rises2 < 32) mosiHdr2 = {mosiHdr2[30:0], ramSi2};
            rises2++;
        end
        if (!ramCeN2 && prevSclk2 && !ramClk2 && rises2 >= 32 && rises2 < 48) begin
            ramSo2 = resp2[47 - rises2];
        end
        if (!prevCe2 && ramCeN2) lastRises2 = rises2;
        if (ramCeN2 && ramClk2) clkIdleBad2++;
        if (rvalid2) rvCount2++;
        prevCe2   = ramCeN2;
        prevSclk2 = ramClk2;
        prevSi2   = ramSi2;
    end

    // Advance to just after the next falling clock edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; the following rising edge is the accept edge
    task automatic applyStimulus(input bit useSecond);
        if (useSecond) start2 = 1'b1;
        else           start1 = 1'b1;
        acceptCycle = cyc + 1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Wait for rvalid with a cycle budget; latency -1 means it never came
    task automatic waitRvalid(input bit useSecond, input int limit, output int latency);
        latency = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if ((useSecond ? rvalid2 : rvalid1) === 1'b1) begin
                latency = cyc - acceptCycle;
                break;
            end
        end
    endtask

    int lat;
    int rv1Cycle;
    int rvBefore;
    bit reached;

    initial begin
        $display("[TB] reset state");
        repeat (3) tick();
        checkOutput("reset_ce_n",   96'(ramCeN1), 96'(1));
        checkOutput("reset_clk",    96'(ramClk1), 96'(0));
        checkOutput("reset_si",     96'(ramSi1),  96'(0));
        checkOutput("reset_busy",   96'(busy1),   96'(0));
        checkOutput("reset_rvalid", 96'(rvalid1), 96'(0));
        checkOutput("reset_rdata",  rdata1,       96'(0));
        resetn = 1'b1;
        repeat (2) tick();

        $display("[TB] default read-ID transaction with stray start pulses");
        applyStimulus(1'b0);
        checkOutput("busy_after_accept", 96'(busy1),   96'(1));
        checkOutput("ce_low_on_accept",  96'(ramCeN1), 96'(0));
        checkOutput("setup_si_cmd_msb",  96'(ramSi1),  96'(1));
        repeat (5) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        waitRvalid(1'b0, 2000, lat);
        checkOutput("latency_default", 96'(lat), 96'(517));
        checkOutput("rdata_default",   rdata1, 96'h0D5D52A60123456789ABCDEF);
        checkOutput("mosi_header",     96'(mosiHdr1), 96'(32'h9F000000));
        checkOutput("sclk_rises",      96'(lastRises1), 96'(128));
        tick();
        checkOutput("rvalid_one_cycle", 96'(rvalid1), 96'(0));
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        checkOutput("busy_in_gap",       96'(busy1), 96'(1));
        tick();
        checkOutput("busy_low_after_gap", 96'(busy1), 96'(0));
        repeat (40) tick();
        checkOutput("stray_start_no_txn", 96'(ramCeN1),  96'(1));
        checkOutput("one_rvalid_per_start", 96'(rvCount1), 96'(1));

        $display("[TB] back-to-back with start held high");
        start1 = 1'b1;
        acceptCycle = cyc + 1;
        waitRvalid(1'b0, 2000, lat);
        checkOutput("latency_b2b_first", 96'(lat), 96'(517));
        rv1Cycle = cyc;
        waitRvalid(1'b0, 2000, lat);
        start1 = 1'b0;
        checkOutput("rvalid_spacing", 96'(cyc - rv1Cycle), 96'(526));
        checkOutput("ce_high_gap",    96'(lastCeRun1), 96'(9));
        checkOutput("rdata_b2b",      rdata1, 96'h0D5D52A60123456789ABCDEF);
        repeat (20) tick();

        $display("[TB] reset during READ");
        applyStimulus(1'b0);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rises1 >= 50) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("reached_bit50", 96'(reached), 96'(1));
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("abort_ce_n",  96'(ramCeN1), 96'(1));
        checkOutput("abort_clk",   96'(ramClk1), 96'(0));
        checkOutput("abort_rdata", rdata1,       96'(0));
        checkOutput("abort_busy",  96'(busy1),   96'(0));
        rvBefore = rvCount1;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (400) tick();
        checkOutput("abort_no_rvalid", 96'(rvCount1), 96'(rvBefore));
        applyStimulus(1'b0);
        waitRvalid(1'b0, 2000, lat);
        checkOutput("latency_after_abort", 96'(lat), 96'(517));
        checkOutput("rdata_after_abort",   rdata1, 96'h0D5D52A60123456789ABCDEF);
        checkOutput("header_after_abort",  96'(mosiHdr1), 96'(32'h9F000000));
        repeat (20) tick();

        $display("[TB] CLK_DIV=1 two-byte READ");
        applyStimulus(1'b1);
        waitRvalid(1'b1, 500, lat);
        checkOutput("latency_div1", 96'(lat), 96'(99));
        checkOutput("rdata_div1",   96'(rdata2), 96'(16'hA53C));
        checkOutput("header_div1",  96'(mosiHdr2), 96'(32'h03123456));
        checkOutput("rises_div1",   96'(lastRises2), 96'(48));
        tick();
        checkOutput("rvalid_one_cycle_div1", 96'(rvalid2), 96'(0));
        checkOutput("rvalid_count_div1", 96'(rvCount2), 96'(1));

        checkOutput("si_stable_at_rise",   96'(siBad1),      96'(0));
        checkOutput("clk_low_when_idle",   96'(clkIdleBad1), 96'(0));
        checkOutput("si_stable_div1",      96'(siBad2),      96'(0));
        checkOutput("clk_low_idle_div1",   96'(clkIdleBad2), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_spi_reader.md
Name: psram_spi_reader

Overview:
- SPI-mode PSRAM read master feeding the 96-bit register-to-UART dump stage.
- Drives RAM_CE_B/RAM_CLK/RAM_SI and samples RAM_SO.
- Each transaction shifts out a command byte and a 24-bit address, then shifts in DATA_BYTES bytes.
- The assembled word is presented on rdata with a one-cycle rvalid pulse; SCLK is a divided, registered clock (never a gated system clock).

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
CMD, 8'h9F, command opcode (9F read-ID, 03 read)
ADDR, 24'h000000, address sent after the command
DATA_BYTES, 12, bytes read per transaction; rdata width = 8*DATA_BYTES
GAP_CYCLES, 8, minimum clk cycles CE stays high between transactions (>=1)

Ports:
clk  in  1  system clock (50 MHz from the PLL)
resetn  in  1  reset, asynchronous, active-low
start  in  1  level request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until GAP ends
rdata  out  8*DATA_BYTES  last completed read word; first received bit is the MSB
rvalid  out  1  one-cycle pulse when rdata updates
ram_ce_n  out  1  chip enable, active-low
ram_clk  out  1  SPI clock, mode 0 (idle low)
ram_si  out  1  MOSI
ram_so  in  1  MISO

Behaviour:
- Reset (async, resetn=0):
  - ram_ce_n=1, ram_clk=0, ram_si=0, busy=0, rvalid=0, rdata=0.
  - State goes to IDLE and all counters clear.
  - Reset mid-transaction aborts immediately: CE goes high in the same instant and no rvalid is issued.
- States: IDLE -> SETUP -> CMD -> ADDR -> READ -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 moves the block to SETUP on the next edge.
  - ram_ce_n falls and busy rises on that edge.
- SETUP:
  - Lasts CLK_DIV cycles with ram_clk=0.
  - ram_si presents bit 7 of CMD.
- Bit timing, every bit in CMD/ADDR/READ:
  - Each bit occupies 2*CLK_DIV cycles: a low half, then a high half.
  - ram_si changes only at the start of a low half.
  - ram_so is sampled into the shift register on the clk edge that raises ram_clk.
  - All outputs are registered.
- CMD sends 8 bits of CMD, MSB first.
- ADDR sends 24 bits of ADDR, MSB first.
- READ:
  - Lasts 8*DATA_BYTES bits; ram_si=0 throughout.
  - Received bits shift in LSB-side: shift left, new bit at bit 0.
  - After the last bit, the first sampled bit sits at rdata MSB.
- HOLD:
  - After the final high half, ram_clk returns low for CLK_DIV cycles while CE stays low.
  - At the end of HOLD: ram_ce_n=1, the internal shift register copies to rdata, and rvalid=1 for exactly that cycle.
- GAP:
  - CE stays high for GAP_CYCLES cycles; busy=1; start is ignored.
  - Then IDLE, where busy=0.
- Latency and back-to-back operation:
  - start accepted to rvalid = 1 + CLK_DIV + (32+8*DATA_BYTES)*2*CLK_DIV + CLK_DIV cycles.
  - Defaults: 1+2+512+2 = 517.
  - start held high gives back-to-back transactions, separated by exactly GAP_CYCLES+1 CE-high cycles.
- rdata holds its value between rvalid pulses and never shows partial data.
- Bit counter width is $clog2(32+8*DATA_BYTES); it has no wrap-around past the last bit.
- start asserted in any state other than IDLE has no effect.

Decomposition:
- Package psram_pkg:
  - Opcodes: READ 8'h03, FAST_READ 8'h0B, READ_ID 8'h9F, RESET_EN 8'h66, RESET 8'h99.
  - State enum (IDLE, SETUP, CMD, ADDR, READ, HOLD, GAP).
  - Header length constant 32.
- One sub-module, psram_spi_shifter:
  - Contains the CLK_DIV divider, SCLK phase generation, and the MOSI/MISO 1-bit shift per bit period.
  - Exposes bit_done and sample strobes to the FSM.

Test Plan:
- Defaults, PSRAM model returns 0D 5D 52 A6 01 23 45 67 89 AB CD EF after the header -> MOSI carries 9F 00 00 00, rdata = 96'h0D5D52A60123456789ABCDEF, rvalid exactly 1 cycle, at 517 cycles after start.
- Waveform check at CLK_DIV=2 -> ram_clk period 4 cycles, 128 rising edges per CE-low window, ram_si stable across every rising edge, ram_clk=0 whenever ram_ce_n=1.
- start held high, GAP_CYCLES=8 -> ram_ce_n high exactly 9 cycles between transactions, second rvalid 526 cycles after the first.
- Reset mid-READ (resetn=0 at bit 50) -> ram_ce_n=1 and ram_clk=0 asynchronously, rdata=0, no rvalid; after release and start, a full correct read follows.
- CLK_DIV=1, CMD=8'h03, ADDR=24'h123456, DATA_BYTES=2, model returns A5 3C -> MOSI 03 12 34 56, rdata=16'hA53C, latency 1+1+96+1=99.
- start pulsed during CMD and during GAP -> ignored; exactly one rvalid per accepted start.
